// File: rtl/padded_strip_writer.sv
`default_nettype none
// ============================================================================
// Module   : padded_strip_writer
// Purpose  : Streams one ROWS x IMG_W pixel strip into window memory as a
//            zero-bordered (IMG_W+2) x (ROWS+2) row-major image.
//            Optional STALL_COUNT_EN adds the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module padded_strip_writer #(
    parameter int IMG_W  = 256,
    parameter int ROWS   = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
`ifdef STALL_COUNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done
);

    localparam int c_PW    = IMG_W + 2;
    localparam int c_COL_W = $clog2(c_PW);
    localparam int c_ROW_W = $clog2(ROWS + 2);

    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(c_PW - 1);
    localparam logic [c_COL_W-1:0] c_COL_DLAST = c_COL_W'(IMG_W);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(ROWS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TOP  = 3'd1,
        ST_LPAD = 3'd2,
        ST_DATA = 3'd3,
        ST_RPAD = 3'd4,
        ST_BOT  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_COL_W-1:0]  r_col;
    logic [c_COL_W-1:0]  w_col_nxt;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_ROW_W-1:0]  w_row_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_waddr;
    logic [7:0]          w_wdata;
    logic                w_we;
    logic                w_last;
    logic                w_accept_start;

    assign in_ready = (r_state == ST_DATA);
    // The accepting edge itself issues the addr-0 pad write.
    assign w_waddr  = w_accept_start ? '0 : r_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_we           = 1'b0;
        w_wdata        = 8'h00;
        w_last         = 1'b0;
        w_accept_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_we           = 1'b1;
                    w_col_nxt      = c_COL_W'(1);
                    w_row_nxt      = '0;
                    w_state_nxt    = ST_TOP;
                end
            end
            ST_TOP: begin
                w_we = 1'b1;
                if (r_col == c_COL_LAST) begin
                    w_col_nxt   = '0;
                    w_row_nxt   = r_row + c_ROW_W'(1);
                    w_state_nxt = ST_LPAD;
                end else begin
                    w_col_nxt = r_col + c_COL_W'(1);
                end
            end
            ST_LPAD: begin
                w_we        = 1'b1;
                w_col_nxt   = r_col + c_COL_W'(1);
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (in_valid) begin
                    w_we      = 1'b1;
                    w_wdata   = in_data;
                    w_col_nxt = r_col + c_COL_W'(1);
                    if (r_col == c_COL_DLAST) begin
                        w_state_nxt = ST_RPAD;
                    end
                end
            end
            ST_RPAD: begin
                w_we        = 1'b1;
                w_col_nxt   = '0;
                w_row_nxt   = r_row + c_ROW_W'(1);
                w_state_nxt = (r_row == c_ROW_LAST) ? ST_BOT : ST_LPAD;
            end
            ST_BOT: begin
                w_we = 1'b1;
                if (r_col == c_COL_LAST) begin
                    w_col_nxt   = '0;
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_col_nxt = r_col + c_COL_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            mem_we  <= w_we;
            done    <= w_last;
            busy    <= (w_state_nxt != ST_IDLE) || w_last;
            if (w_we) begin
                r_addr    <= w_waddr + ADDR_W'(1);
                mem_addr  <= w_waddr;
                mem_wdata <= w_wdata;
            end
        end
    end

`ifdef STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || w_accept_start) begin
            stall_cnt <= 16'h0000;
        end else if ((r_state == ST_DATA) && !in_valid && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_padded_strip_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_padded_strip_writer
// Purpose  : Randomized scoreboard bench for padded_strip_writer; expected
//            writes come from a padded-image model built from the pixel list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_padded_strip_writer;

    localparam int IMG_W  = 256;
    localparam int ROWS   = 32;
    localparam int ADDR_W = 14;
    localparam int PW     = IMG_W + 2;
    localparam int DEPTH  = (ROWS + 2) * PW;
    localparam int NPIX   = IMG_W * ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
`ifdef STALL_COUNT_EN
    logic [15:0]       stall_cnt;
`endif

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  pix [0:2*NPIX-1];
    int  addr0_cycs[$];
    int  done_cycs[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;

    padded_strip_writer #(
        .IMG_W (IMG_W),
        .ROWS  (ROWS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
`ifdef STALL_COUNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0d (no write expected)", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (mem_addr !== mon_e.addr[ADDR_W-1:0] || mem_wdata !== mon_e.data[7:0]) begin
                    failures++;
                    $display("FAIL write_seq addr=%0d data=%0d expected addr=%0d data=%0d",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
                checks++;
                if (done !== (mon_e.addr == DEPTH - 1)) begin
                    failures++;
                    $display("FAIL done_flag at addr=%0d done=%0b expected=%0b",
                             mon_e.addr, done, (mon_e.addr == DEPTH - 1));
                end
                if (mon_e.addr == 0) addr0_cycs.push_back(cyc);
                if (done === 1'b1) done_cycs.push_back(cyc);
            end
        end else if (!rst && done === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_without_write done=1 expected mem_we=1");
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic gen_pix(input bit incr);
        for (int i = 0; i < 2*NPIX; i++) pix[i] = incr ? (i % 256) : int'($urandom_range(255));
    endtask

    // Padded-image reference: border cells are zero, interior holds the pixel list.
    task automatic push_strip(input int base);
        wr_t w;
        for (int a = 0; a < DEPTH; a++) begin
            int r = a / PW;
            int c = a % PW;
            w.addr = a;
            if (r >= 1 && r <= ROWS && c >= 1 && c <= IMG_W)
                w.data = pix[base + (r - 1) * IMG_W + (c - 1)];
            else
                w.data = 0;
            exp_q.push_back(w);
        end
    endtask

    // Called at a negedge with start already raised for the first cycle.
    task automatic feed(input int npix, input int stall_pct, input bit pulse100, input bit hold,
                        input int abort_addr, output int stalls, output int ready_low, output bit aborted);
        int idx = 0;
        int iter = 0;
        bit seen_ready = 0;
        bit rdy;
        stalls = 0;
        ready_low = 0;
        aborted = 0;
        while (idx < npix && iter < 40000) begin
            if (iter > 0) begin
                if (hold) start = (idx <= NPIX);
                else if (pulse100) start = (mem_we && mem_addr == 100);
                else start = 1'b0;
            end
            if (abort_addr >= 0 && mem_we && mem_addr == abort_addr[ADDR_W-1:0]) begin
                aborted = 1;
                rst = 1'b1;
                start = 1'b0;
                in_valid = 1'b0;
                break;
            end
            in_valid = ($urandom_range(99) >= stall_pct);
            in_data = pix[idx][7:0];
            rdy = in_ready;
            if (!rdy && !seen_ready) ready_low++;
            if (rdy) seen_ready = 1;
            if (rdy && !in_valid) stalls++;
            @(posedge clk);
            if (in_valid && rdy) idx++;
            @(negedge clk);
            iter++;
        end
        in_valid = 1'b0;
        if (!hold) start = 1'b0;
        if (idx < npix && !aborted) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout accepted=%0d expected=%0d", idx, npix);
        end
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        #1;
        while (done !== 1'b1 && g < 30000) begin
            @(negedge clk);
            #1;
            g++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout done=%0b expected=1", name, done);
        end
    endtask

    int  stalls;
    int  ready_low;
    bit  aborted;
    int  start_cyc;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
`ifdef STALL_COUNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Strip 1: no stalls, incrementing data, in_valid high through TOP.
        gen_pix(1);
        push_strip(0);
        addr0_cycs.delete();
        done_cycs.delete();
        start_cyc = cyc + 1;
        start = 1'b1;
        feed(NPIX, 0, 0, 0, -1, stalls, ready_low, aborted);
        wait_done("nostall");
        chk("nostall_busy_at_done", busy, 1);
        chk("nostall_ready_low_cycles", ready_low, 259);
        if (addr0_cycs.size() == 1 && done_cycs.size() == 1) begin
            chk("nostall_first_write_cycle", addr0_cycs[0] - start_cyc, 0);
            chk("nostall_done_cycle", done_cycs[0] - start_cyc, DEPTH - 1);
        end else begin
            chk("nostall_event_count", addr0_cycs.size() * 10 + done_cycs.size(), 11);
        end
`ifdef STALL_COUNT_EN
        chk("nostall_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        #1;
        chk("nostall_busy_after_done", busy, 0);
        chk("nostall_we_after_done", mem_we, 0);
        chk("nostall_queue_empty", exp_q.size(), 0);

        // Strip 2: random data with ~30% stalls in DATA.
        gen_pix(0);
        push_strip(0);
        start = 1'b1;
        feed(NPIX, 30, 0, 0, -1, stalls, ready_low, aborted);
        wait_done("stall");
`ifdef STALL_COUNT_EN
        chk("stall_cnt_at_done", stall_cnt, stalls);
`endif
        @(negedge clk);
        #1;
        chk("stall_queue_empty", exp_q.size(), 0);
        chk("stall_busy_after_done", busy, 0);
`ifdef STALL_COUNT_EN
        chk("stall_cnt_holds", stall_cnt, stalls);
`endif

        // Strip 3: reset asserted while mem_addr=4000 is on the bus.
        gen_pix(0);
        push_strip(0);
        start = 1'b1;
        feed(NPIX, 20, 0, 0, 4000, stalls, ready_low, aborted);
        chk("abort_reached_4000", aborted, 1);
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_idle_busy", busy, 0);

        // Strip 4: restart from addr 0, start pulsed mid-strip at addr 100.
        gen_pix(0);
        push_strip(0);
        addr0_cycs.delete();
        start_cyc = cyc + 1;
        start = 1'b1;
        feed(NPIX, 10, 1, 0, -1, stalls, ready_low, aborted);
        wait_done("restart");
        if (addr0_cycs.size() == 1) chk("restart_first_write_cycle", addr0_cycs[0] - start_cyc, 0);
        else chk("restart_addr0_count", addr0_cycs.size(), 1);
        @(negedge clk);
        #1;
        chk("restart_queue_empty", exp_q.size(), 0);

        // Strips 5+6: start held high, second strip follows done immediately.
        gen_pix(1);
        push_strip(0);
        push_strip(NPIX);
        addr0_cycs.delete();
        done_cycs.delete();
        start = 1'b1;
        feed(2*NPIX, 0, 0, 1, -1, stalls, ready_low, aborted);
        start = 1'b0;
        wait_done("held");
        chk("held_done_count", done_cycs.size(), 2);
        chk("held_addr0_count", addr0_cycs.size(), 2);
        if (done_cycs.size() == 2 && addr0_cycs.size() == 2) begin
            chk("held_restart_gap", addr0_cycs[1] - done_cycs[0], 1);
            chk("held_second_done_cycle", done_cycs[1] - addr0_cycs[1], DEPTH - 1);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("held_queue_empty", exp_q.size(), 0);
        chk("held_busy_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
